// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sine generator.
//   - dds_state_e   : sequencer states
//   - MIDSCALE      : offset-binary zero level of the output sample
//   - DEF_FTW0..3   : default tuning words for modes 0-3
//   - FLUSH_CYCLES  : length of the retune window
//   - MODE_COUNT    : number of modes with a non-zero tuning word
//   - quarter_sine(): elaboration-time generator for the quarter-wave table
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } dds_state_e;

    localparam logic [13:0] MIDSCALE     = 14'd8192;
    localparam logic [23:0] DEF_FTW0     = 24'h010000;
    localparam logic [23:0] DEF_FTW1     = 24'h020000;
    localparam logic [23:0] DEF_FTW2     = 24'h040000;
    localparam logic [23:0] DEF_FTW3     = 24'h080000;
    localparam int          FLUSH_CYCLES = 3;
    localparam int          MODE_COUNT   = 4;

    // pi in Q30 fixed point
    localparam longint SINE_PI_Q30 = 64'sd3373259426;

    // round(amp * sin(pi/2 * (k + 0.5) / 2**addr_w)), evaluated with a
    // Q30 Taylor series so the table needs no external data file.
    function automatic int quarter_sine(input int k, input int addr_w, input int amp);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (SINE_PI_Q30 * longint'(2 * k + 1)) >>> (addr_w + 2);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return int'((longint'(amp) * acc + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/dds_quarter_sine_rom.sv
// Synchronous quarter-wave sine ROM, one cycle read latency.
// Ports:
//   Fg_CLK  in   clock
//   addr_i  in   ADDR_W   table index
//   data_o  out  DATA_W-1 magnitude, registered
module dds_quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 14
) (
    input  logic              Fg_CLK,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-2:0] data_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int AMP   = (1 << (DATA_W - 1)) - 1;

    logic [DATA_W-2:0] table_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        assign table_w[k] = (DATA_W-1)'(quarter_sine(k, ADDR_W, AMP));
    end

    always_ff @(posedge Fg_CLK) begin
        data_o <= table_w[addr_i];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS sine generator fed by the sampling controller.
// Ports:
//   Fg_CLK     in   clock
//   Fg_RESETn  in   async active-low reset
//   DDSEnable  in   one-cycle sample strobe
//   DDSReady   in   one-cycle arm pulse
//   DDSMode    in   3        frequency select (4-7 give a frozen phase)
//   WaveOut    out  DATA_W   offset-binary sine sample
//   WaveValid  out  one-cycle strobe, WaveOut updated this cycle
//   WaveArmed  out  high while running
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for DDSReady, strobes ignored
// ST_RUN   | each strobe issues a sample and advances the phase
// ST_FLUSH | retune window: mode/FTW reload, phase cleared, no samples
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int                 PHASE_W = 24,
    parameter int                 ADDR_W  = 8,
    parameter int                 DATA_W  = 14,
    parameter logic [PHASE_W-1:0] FTW0    = DEF_FTW0,
    parameter logic [PHASE_W-1:0] FTW1    = DEF_FTW1,
    parameter logic [PHASE_W-1:0] FTW2    = DEF_FTW2,
    parameter logic [PHASE_W-1:0] FTW3    = DEF_FTW3
) (
    input  logic              Fg_CLK,
    input  logic              Fg_RESETn,
    input  logic              DDSEnable,
    input  logic              DDSReady,
    input  logic [2:0]        DDSMode,
    output logic [DATA_W-1:0] WaveOut,
    output logic              WaveValid,
    output logic              WaveArmed
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);

    dds_state_e         state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [1:0]         flush_cnt_q, flush_cnt_d;
    logic               s1_vld_q, s1_vld_d;
    logic [1:0]         s1_quad_q, s1_quad_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
    logic               s2_vld_q, s2_vld_d;
    logic [1:0]         s2_quad_q, s2_quad_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               kill;
    logic [DATA_W-2:0]  rom_data;

    function automatic logic [PHASE_W-1:0] ftw_sel(input logic [2:0] mode);
        logic [PHASE_W-1:0] ftw;
        case (mode)
            3'd0:    ftw = FTW0;
            3'd1:    ftw = FTW1;
            3'd2:    ftw = FTW2;
            3'd3:    ftw = FTW3;
            default: ftw = '0;
        endcase
        return ftw;
    endfunction

    dds_quarter_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .Fg_CLK (Fg_CLK),
        .addr_i (s1_addr_q),
        .data_o (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ftw_d       = ftw_q;
        acc_d       = acc_q;
        flush_cnt_d = flush_cnt_q;
        kill        = 1'b0;
        s1_vld_d    = 1'b0;
        s1_quad_d   = s1_quad_q;
        s1_addr_d   = s1_addr_q;
        s2_vld_d    = s1_vld_q;
        s2_quad_d   = s1_quad_q;
        out_vld_d   = s2_vld_q;
        out_d       = out_q;
        if (s2_vld_q) begin
            out_d = s2_quad_q[1] ? (MID - {1'b0, rom_data}) : (MID + {1'b0, rom_data});
        end

        unique case (state_q)
            ST_IDLE: begin
                if (DDSReady) begin
                    state_d = ST_RUN;
                    mode_d  = DDSMode;
                    ftw_d   = ftw_sel(DDSMode);
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                // A mode change wins over a strobe in the same cycle.
                if (DDSMode != mode_q) begin
                    state_d     = ST_FLUSH;
                    mode_d      = DDSMode;
                    ftw_d       = ftw_sel(DDSMode);
                    acc_d       = '0;
                    flush_cnt_d = 2'(FLUSH_CYCLES - 1);
                    kill        = 1'b1;
                end else if (DDSEnable) begin
                    s1_vld_d  = 1'b1;
                    s1_quad_d = acc_q[PHASE_W-1 -: 2];
                    // Odd quadrants walk the table backwards.
                    s1_addr_d = acc_q[PHASE_W-2] ? ~acc_q[PHASE_W-3 -: ADDR_W]
                                                 :  acc_q[PHASE_W-3 -: ADDR_W];
                    acc_d     = acc_q + ftw_q;
                end
            end
            ST_FLUSH: begin
                mode_d = DDSMode;
                ftw_d  = ftw_sel(DDSMode);
                acc_d  = '0;
                kill   = 1'b1;
                if (DDSMode != mode_q) begin
                    flush_cnt_d = 2'(FLUSH_CYCLES - 1);
                end else if (flush_cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // In-flight samples are discarded and WaveOut holds across a retune.
        if (kill) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            out_vld_d = 1'b0;
            out_d     = out_q;
        end
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            ftw_q       <= '0;
            acc_q       <= '0;
            flush_cnt_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_quad_q   <= '0;
            s1_addr_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_quad_q   <= '0;
            out_q       <= MID;
            out_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ftw_q       <= ftw_d;
            acc_q       <= acc_d;
            flush_cnt_q <= flush_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_quad_q   <= s1_quad_d;
            s1_addr_q   <= s1_addr_d;
            s2_vld_q    <= s2_vld_d;
            s2_quad_q   <= s2_quad_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
        end
    end

    assign WaveOut   = out_q;
    assign WaveValid = out_vld_q;
    assign WaveArmed = (state_q == ST_RUN);

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed start-up/retune/reset
// scenarios plus randomized traffic, checked every cycle against a
// behavioural model that derives samples directly from sin().
module tb_dds_wave_gen;

    localparam real PI        = 3.14159265358979323846;
    localparam int  FLUSH_LEN = 3;
    localparam int  PHASE_MOD = 1 << 24;

    logic        Fg_CLK = 1'b0;
    logic        Fg_RESETn;
    logic        DDSEnable;
    logic        DDSReady;
    logic [2:0]  DDSMode;
    logic [13:0] WaveOut;
    logic        WaveValid;
    logic        WaveArmed;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int val;
        int left;
    } pend_t;

    pend_t pend_q[$];
    bit    m_armed;
    int    m_flush_left;
    int    m_mode;
    longint m_phase;
    bit    m_exp_valid;
    int    m_exp_out;

    dds_wave_gen dut (
        .Fg_CLK    (Fg_CLK),
        .Fg_RESETn (Fg_RESETn),
        .DDSEnable (DDSEnable),
        .DDSReady  (DDSReady),
        .DDSMode   (DDSMode),
        .WaveOut   (WaveOut),
        .WaveValid (WaveValid),
        .WaveArmed (WaveArmed)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ideal sine sampled at the centre of the 1/1024-period slot the phase falls in.
    function automatic int ref_sample(input longint phase);
        int  idx;
        real v;
        real a;
        int  mag;
        idx = int'(phase >> 14);
        v   = 8191.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 1024.0);
        a   = (v < 0.0) ? -v : v;
        mag = $rtoi(a + 0.5);
        return (v < 0.0) ? 8192 - mag : 8192 + mag;
    endfunction

    function automatic longint ftw_of(input int mode);
        return (mode < 4) ? (longint'(65536) << mode) : 0;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_armed      = 1'b0;
        m_flush_left = 0;
        m_mode       = 0;
        m_phase      = 0;
        m_exp_valid  = 1'b0;
        m_exp_out    = 8192;
    endtask

    task automatic model_step(input bit en, input bit rdy, input int mode);
        bit kill;
        bit accept;
        kill   = 1'b0;
        accept = 1'b0;
        if (!Fg_RESETn) begin
            model_reset();
            return;
        end
        if (!m_armed) begin
            if (rdy) begin
                m_armed = 1'b1;
                m_mode  = mode;
                m_phase = 0;
            end
        end else if (m_flush_left > 0) begin
            kill    = 1'b1;
            m_phase = 0;
            if (mode != m_mode) begin
                m_mode       = mode;
                m_flush_left = FLUSH_LEN;
            end else begin
                m_flush_left--;
            end
        end else if (mode != m_mode) begin
            kill         = 1'b1;
            m_mode       = mode;
            m_phase      = 0;
            m_flush_left = FLUSH_LEN;
        end else if (en) begin
            accept = 1'b1;
        end

        m_exp_valid = 1'b0;
        if (kill) begin
            pend_q.delete();
        end else begin
            foreach (pend_q[i]) pend_q[i].left--;
            if (pend_q.size() > 0 && pend_q[0].left == 0) begin
                m_exp_valid = 1'b1;
                m_exp_out   = pend_q[0].val;
                void'(pend_q.pop_front());
            end
        end
        if (accept) begin
            pend_q.push_back('{ref_sample(m_phase), 2});
            m_phase = (m_phase + ftw_of(m_mode)) % PHASE_MOD;
        end
    endtask

    task automatic cycle(input bit en, input bit rdy, input int mode);
        DDSEnable = en;
        DDSReady  = rdy;
        DDSMode   = 3'(mode);
        @(posedge Fg_CLK);
        #1;
        model_step(en, rdy, mode);
        check_val("valid", int'(WaveValid), int'(m_exp_valid));
        check_val("out",   int'(WaveOut),   m_exp_out);
        check_val("armed", int'(WaveArmed), int'(m_armed && m_flush_left == 0));
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic async_reset_pulse(input int mode);
        #2;
        Fg_RESETn = 1'b0;
        #1;
        check_val("rst_async_out",   int'(WaveOut),   8192);
        check_val("rst_async_valid", int'(WaveValid), 0);
        check_val("rst_async_armed", int'(WaveArmed), 0);
        model_reset();
        cycle(1'b1, 1'b0, mode);
        cycle(1'b1, 1'b1, mode);
        Fg_RESETn = 1'b1;
    endtask

    initial begin
        int  start_exp [5];
        int  start_idx [5];
        int  cur_mode;
        bit  en;
        bit  rdy;

        Fg_RESETn = 1'b0;
        DDSEnable = 1'b0;
        DDSReady  = 1'b0;
        DDSMode   = 3'd0;
        model_reset();

        // Reset state
        cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        check_val("reset_out",   int'(WaveOut),   8192);
        check_val("reset_valid", int'(WaveValid), 0);
        check_val("reset_armed", int'(WaveArmed), 0);
        Fg_RESETn = 1'b1;

        // Arm gating: strobes without DDSReady do nothing
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 0);
            cycle(1'b0, 1'b0, 0);
            check_val("gate_valid", int'(WaveValid), 0);
            check_val("gate_out",   int'(WaveOut),   8192);
            check_val("gate_armed", int'(WaveArmed), 0);
        end

        // Start-up in mode 0, strobe every 4 cycles
        start_idx = '{0, 64, 128, 192, 256};
        start_exp = '{8217, 16383, 8167, 1, 8217};
        cycle(1'b0, 1'b1, 0);
        check_val("armed_after_ready", int'(WaveArmed), 1);
        for (int n = 0; n <= 256; n++) begin
            cycle(1'b1, 1'b0, 0);
            cycle(1'b0, 1'b0, 0);
            cycle(1'b0, 1'b0, 0);
            for (int j = 0; j < 5; j++) begin
                if (n == start_idx[j]) begin
                    check_val($sformatf("start_s%0d_valid", n), int'(WaveValid), 1);
                    check_val($sformatf("start_s%0d", n),       int'(WaveOut),   start_exp[j]);
                end
            end
            cycle(1'b0, 1'b0, 0);
        end

        // Retune 0->2 on a strobe cycle: strobe dropped, 3-cycle flush, output held
        for (int k = 0; k < 4; k++) begin
            cycle(k == 0, 1'b0, 2);
            check_val("flush_valid", int'(WaveValid), 0);
            check_val("flush_hold",  int'(WaveOut),   8217);
            check_val("flush_armed", int'(WaveArmed), (k < 3) ? 0 : 1);
        end
        for (int n = 0; n <= 16; n++) begin
            cycle(1'b1, 1'b0, 2);
            cycle(1'b0, 1'b0, 2);
            cycle(1'b0, 1'b0, 2);
            if (n == 0)  check_val("retune_s0",  int'(WaveOut), 8217);
            if (n == 16) check_val("retune_s16", int'(WaveOut), 16383);
            cycle(1'b0, 1'b0, 2);
        end

        // Continuous strobes in mode 3
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 3);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, 3);
            if (i >= 2) begin
                check_val("cont_valid", int'(WaveValid), 1);
                if ((i - 2) % 32 == 0) check_val("cont_s0",  int'(WaveOut), 8217);
                if ((i - 2) % 32 == 8) check_val("cont_s8",  int'(WaveOut), 16383);
                if ((i - 2) % 32 == 24) check_val("cont_s24", int'(WaveOut), 1);
            end
        end

        // Invalid mode: frozen phase
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 5);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 5);
            if (i >= 2) begin
                check_val("inval_valid", int'(WaveValid), 1);
                check_val("inval_out",   int'(WaveOut),   8217);
            end
        end

        // Reset mid-stream, then strobes without re-arm
        async_reset_pulse(5);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 0);
            check_val("post_rst_valid", int'(WaveValid), 0);
            check_val("post_rst_armed", int'(WaveArmed), 0);
        end

        // Randomized traffic
        cur_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) cur_mode = int'($urandom_range(0, 7));
            en  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 3);
            cycle(en, rdy, cur_mode);
            if ($urandom_range(0, 999) < 3) async_reset_pulse(cur_mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
